mem_port_arbiter: RTL

- Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage.
- Sequences each access with a req/ack handshake toward the memory.
- Returns fetched instructions and load data with a one-cycle valid pulse.
- Drives per-requester stall outputs that the pipeline ORs into its existing stall/freeze logic.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side and memory-side signals of the unified memory port arbiter.
// master: the arbiter's view (drives completions, stalls and the memory request).
// slave : the environment's view (IF/MEM stages plus memory model).
interface mem_port_arbiter_if;
  // instruction-fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_stall;
  // data-memory side
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;
  // memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_inst, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_inst, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch and data access.
// Latency: request seen in cycle N -> mem_req at N+1 -> valid at N+2 with an immediate ack.
// Backpressure: requesters hold req until their valid pulse; stalls are req & ~valid.
// Ports: clk/rst (sync active-high); bus (master modport) carries the IF request/return,
// the DM request/return, the registered memory request and the bus_err abort pulse.
// Optional: define MEMARB_STARVE_GUARD_EN to force a fetch after MAX_DATA_STREAK data grants.
module mem_port_arbiter #(
  parameter int TIMEOUT         = 16,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] INST = 2'd2;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_inst_q;
  logic [31:0] dm_rdata_q;
  logic        if_valid_q;
  logic        dm_valid_q;
  logic        bus_err_q;

  logic        completing;
  logic        force_if;
  logic        grant_dm;
  logic        grant_if;

  // No grant at all in a completion cycle: the finishing requester still shows
  // its old req, and letting the other side in here would let a fetch slip
  // past a data stage that re-requests straight away.
  assign completing = if_valid_q | dm_valid_q;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam logic [2:0] STREAK_MAX = 3'(MAX_DATA_STREAK);

  // Consecutive data grants made while a fetch was waiting.
  logic [2:0] streak;

  assign force_if = (streak >= STREAK_MAX) & bus.if_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= 3'd0;
    end else if (grant_if) begin
      streak <= 3'd0;
    end else if (grant_dm) begin
      if (!bus.if_req)
        streak <= 3'd0;
      else if (streak != 3'd7)
        streak <= streak + 3'd1;
    end
  end
`else
  // Strict data priority; the streak limit only matters with the guard enabled,
  // so keep it referenced here without building any logic from it.
  logic unused_streak_cfg;
  assign unused_streak_cfg = (MAX_DATA_STREAK != 0);
  assign force_if          = 1'b0;
`endif

  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE && !completing) begin
      if (bus.dm_req && !force_if)
        grant_dm = 1'b1;
      else if (bus.if_req)
        grant_if = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_inst_q   <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state       <= DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            wait_cnt    <= 8'd0;
          end else if (grant_if) begin
            state      <= INST;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.if_addr;
            wait_cnt   <= 8'd0;
          end
        end
        DATA, INST: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            if (state == DATA) begin
              dm_valid_q <= 1'b1;
              if (!mem_we_q)
                dm_rdata_q <= bus.mem_rdata;
            end else begin
              if_valid_q <= 1'b1;
              if_inst_q  <= bus.mem_rdata;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Abort: complete with zero data (a NOP for fetch); a store is lost.
            state     <= IDLE;
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (state == DATA) begin
              dm_valid_q <= 1'b1;
              if (!mem_we_q)
                dm_rdata_q <= 32'd0;
            end else begin
              if_valid_q <= 1'b1;
              if_inst_q  <= 32'd0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;

endmodule
